// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word lines and LRU replacement.
// Lookups are combinational. A 32-bit instruction may straddle two lines. Misses
// refill one whole line through a request/beat handshake that the FSM below runs.
module icache_assoc #(
  parameter int WAYS         = 2,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int ADDR_WIDTH   = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        need_flush_in,
  input  logic        invalidate_in,
  input  logic        if_valid,
  input  logic [31:0] if_instr_addr,
  output logic        hit_out,
  output logic [31:0] instr_out,
  output logic        busy_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << (OFFSET_WIDTH - 2);
  localparam int TAG_W      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_W     = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                      32'((64'd1 << ADDR_WIDTH) - 64'd1);
  localparam logic [WORD_W-1:0] LAST = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  // Address field extraction; bits above ADDR_WIDTH fall off in the tag cast.
  function automatic logic [INDEX_WIDTH-1:0] set_of(input logic [31:0] a);
    return INDEX_WIDTH'(a >> OFFSET_WIDTH);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return TAG_W'(a >> (INDEX_WIDTH + OFFSET_WIDTH));
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [31:0] a);
    return WORD_W'((a & LINE_MASK) >> 2);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ADDR_MASK & ~LINE_MASK;
  endfunction

  function automatic logic [15:0] half_of(input logic [31:0] w, input logic upper);
    return upper ? w[31:16] : w[15:0];
  endfunction

  // Storage arrays; only valid (and LRU) bits carry reset.
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
  logic             valid_q [WAYS][SETS];
  logic [31:0]      buf_q   [LINE_WORDS];

  state_t            state_q, state_n;
  logic              mem_req_q, busy_q, inv_pend_q, inv_pend_n;
  logic [31:0]       mem_addr_q;
  logic [WORD_W-1:0] cnt_q;
  logic              fill_done, fill_we, beat, inv_apply;
  logic              victim;

  logic [31:0]            lo, hi, miss_line;
  logic [INDEX_WIDTH-1:0] lo_set, hi_set, fill_set;
  logic [TAG_W-1:0]       lo_tag, hi_tag, fill_tag;
  logic                   lo_hit, hi_hit, lo_way;
  logic [31:0]            lo_word, hi_word;
  logic [15:0]            lo_half, hi_half;
  logic                   is32;

  assign lo       = if_instr_addr;
  assign hi       = if_instr_addr + 32'd2;
  assign lo_set   = set_of(lo);
  assign hi_set   = set_of(hi);
  assign lo_tag   = tag_of(lo);
  assign hi_tag   = tag_of(hi);
  assign fill_set = set_of(mem_addr_q);
  assign fill_tag = tag_of(mem_addr_q);

  // Tag compare for both halves of the fetch across every way.
  always_comb begin
    lo_hit  = 1'b0;
    lo_way  = 1'b0;
    lo_word = '0;
    hi_hit  = 1'b0;
    hi_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][lo_set] && tag_q[w][lo_set] == lo_tag) begin
        lo_hit  = 1'b1;
        lo_way  = 1'(w);
        lo_word = data_q[w][lo_set][word_of(lo)];
      end
      if (valid_q[w][hi_set] && tag_q[w][hi_set] == hi_tag) begin
        hi_hit  = 1'b1;
        hi_word = data_q[w][hi_set][word_of(hi)];
      end
    end
  end

  assign lo_half   = half_of(lo_word, lo[1]);
  assign hi_half   = half_of(hi_word, hi[1]);
  assign is32      = (lo_half[1:0] == 2'b11);
  assign hit_out   = if_valid && lo_hit && (!is32 || hi_hit);
  assign miss_line = line_of(lo_hit ? hi : lo);

  // Assemble the instruction; 16-bit forms are zero-extended, misses read 0.
  always_comb begin
    instr_out = '0;
    if (hit_out) instr_out = is32 ? {hi_half, lo_half} : {16'h0000, lo_half};
  end

  // Refill FSM next-state; a flush only cancels a request not yet accepted.
  always_comb begin
    state_n   = state_q;
    fill_done = 1'b0;
    case (state_q)
      IDLE: if (if_valid && !hit_out && !need_flush_in) state_n = REQ;
      REQ: begin
        if (!mem_busy)          state_n = FILL;
        else if (need_flush_in) state_n = IDLE;
      end
      FILL: begin
        if (mem_valid && cnt_q == LAST) begin
          fill_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Invalidation requested while busy waits until the line write has landed.
  always_comb begin
    inv_pend_n = inv_pend_q;
    if (state_q == IDLE)    inv_pend_n = 1'b0;
    else if (invalidate_in) inv_pend_n = 1'b1;
  end

  assign inv_apply = (state_q == IDLE) && (invalidate_in || inv_pend_q);
  assign beat      = rdy_in && (state_q == FILL) && mem_valid;
  assign fill_we   = rdy_in && !rst_in && fill_done;

  // Control registers: state, request, address, beat counter, busy, pending invalidate.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      inv_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else if (rdy_in) begin
      state_q    <= state_n;
      mem_req_q  <= (state_n == REQ);
      busy_q     <= (state_n != IDLE) || inv_pend_n;
      inv_pend_q <= inv_pend_n;
      if (state_q == IDLE && state_n == REQ) mem_addr_q <= miss_line;
      if (state_q == REQ && state_n == FILL) cnt_q <= '0;
      else if (beat)                         cnt_q <= cnt_q + WORD_W'(1);
    end
  end

  assign mem_req_out  = mem_req_q;
  assign mem_addr_out = mem_addr_q;
  assign busy_out     = busy_q;

  // Valid bits: whole-cache clear on invalidation, set on line write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
    end else if (rdy_in) begin
      if (inv_apply) begin
        for (int w = 0; w < WAYS; w++)
          for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
      end else if (fill_we) begin
        valid_q[victim][fill_set] <= 1'b1;
      end
    end
  end

  if (WAYS == 2) begin : g_lru
    logic lru_q [SETS];

    // Prefer an invalid way (lowest first), else the least recently used one.
    assign victim = !valid_q[0][fill_set] ? 1'b0 :
                    !valid_q[1][fill_set] ? 1'b1 : lru_q[fill_set];

    // LRU bit names the way to evict next; hits and fills make their way recent.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
      end else if (rdy_in) begin
        if (inv_apply) begin
          for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
        end else begin
          if (hit_out) lru_q[lo_set]   <= ~lo_way;
          if (fill_we) lru_q[fill_set] <= ~victim;
        end
      end
    end
  end else begin : g_nolru
    assign victim = 1'b0;
  end

  // Beat capture into the fill buffer and line write on the final beat.
  always_ff @(posedge clk_in) begin
    if (beat && !rst_in) buf_q[cnt_q] <= mem_data;
    if (fill_we) begin
      tag_q[victim][fill_set] <= fill_tag;
      for (int k = 0; k < LINE_WORDS; k++)
        data_q[victim][fill_set][k] <= (WORD_W'(k) == LAST) ? mem_data : buf_q[k];
    end
  end

endmodule
